// File: rtl/mvm_pkg.sv
// mvm_pkg: shared sizes and loader state encoding for the matrix-vector unit
package mvm_pkg;
   localparam int MVM_WIDTH = 16;
   localparam int MVM_ROWS  = 8;
   localparam int MVM_COLS  = 8;
   localparam int MVM_MLOG  = 6;
   localparam int MVM_VLOG  = 3;
   typedef enum logic [2:0] {IDLE, LOAD_M, LOAD_V, DRAIN, START, BUSY} loader_state_t;
endpackage

// File: rtl/mvm_addr_counter.sv
// mvm_addr_counter: sequential address counter that wraps to 0 after its terminal count
module mvm_addr_counter #(
   parameter int W  = 3,
   parameter int TC = 7
) (
   input  logic         clk,
   input  logic         i_clr,
   input  logic         i_en,
   output logic [W-1:0] o_cnt,
   output logic         o_tc
);
   localparam logic [W-1:0] L_TC = W'(TC);
   logic [W-1:0] r_cnt;
   assign o_cnt = r_cnt;
   assign o_tc  = r_cnt == L_TC;
   always_ff @(posedge clk)
      if (i_clr) r_cnt <= '0;
      else if (i_en) r_cnt <= o_tc ? '0 : r_cnt + W'(1);
endmodule

// File: rtl/mvm_input_loader.sv
// mvm_input_loader: streams words into matrix/vector memories, then starts the MAC datapath
module mvm_input_loader
   import mvm_pkg::*;
#(
   parameter int WIDTH = MVM_WIDTH,
   parameter int ROWS  = MVM_ROWS,
   parameter int COLS  = MVM_COLS,
   parameter int MLOG  = MVM_MLOG,
   parameter int VLOG  = MVM_VLOG
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] s_data,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic             s_new_matrix,
   output logic [MLOG-1:0]  m_addr,
   output logic [WIDTH-1:0] m_data,
   output logic             m_wr_en,
   output logic [VLOG-1:0]  v_addr,
   output logic [WIDTH-1:0] v_data,
   output logic             v_wr_en,
   output logic             start,
   input  logic             compute_done
);
   loader_state_t r_state, w_state_nxt;
   logic r_ready, r_drain, r_matrix_valid;
   logic r_m_wr_en, r_v_wr_en;
   logic [MLOG-1:0] r_m_addr, w_mcnt;
   logic [VLOG-1:0] r_v_addr, w_vcnt;
   logic [WIDTH-1:0] r_m_data, r_v_data;
   logic w_hs, w_eff_new, w_m_en, w_v_en, w_m_tc, w_v_tc;
   assign w_hs      = s_valid & r_ready;
   assign w_eff_new = s_new_matrix | ~r_matrix_valid;
   // the first beat of a load writes address 0 of whichever memory it selects
   assign w_m_en = w_hs & ((r_state == LOAD_M) | ((r_state == IDLE) & w_eff_new));
   assign w_v_en = w_hs & ((r_state == LOAD_V) | ((r_state == IDLE) & ~w_eff_new));
   mvm_addr_counter #(.W(MLOG), .TC(ROWS*COLS-1)) u_mcnt (
      .clk(clk), .i_clr(reset), .i_en(w_m_en), .o_cnt(w_mcnt), .o_tc(w_m_tc));
   mvm_addr_counter #(.W(VLOG), .TC(COLS-1)) u_vcnt (
      .clk(clk), .i_clr(reset), .i_en(w_v_en), .o_cnt(w_vcnt), .o_tc(w_v_tc));
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_hs) w_state_nxt = w_eff_new ? LOAD_M : LOAD_V;
         LOAD_M:  if (w_hs && w_m_tc) w_state_nxt = LOAD_V;
         LOAD_V:  if (w_hs && w_v_tc) w_state_nxt = DRAIN;
         DRAIN:   if (r_drain) w_state_nxt = START;
         START:   w_state_nxt = BUSY;
         BUSY:    if (compute_done) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end
   // ready is registered from the next state so it stays low in the cycle after reset
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= IDLE;
         r_ready        <= 1'b0;
         r_drain        <= 1'b0;
         r_matrix_valid <= 1'b0;
         r_m_wr_en      <= 1'b0;
         r_v_wr_en      <= 1'b0;
         r_m_addr       <= '0;
         r_v_addr       <= '0;
         r_m_data       <= '0;
         r_v_data       <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_ready   <= w_state_nxt inside {IDLE, LOAD_M, LOAD_V};
         r_drain   <= (r_state == DRAIN) & ~r_drain;
         if (w_hs && r_state == LOAD_M && w_m_tc) r_matrix_valid <= 1'b1;
         r_m_wr_en <= w_m_en;
         r_v_wr_en <= w_v_en;
         if (w_m_en) begin
            r_m_addr <= w_mcnt;
            r_m_data <= s_data;
         end
         if (w_v_en) begin
            r_v_addr <= w_vcnt;
            r_v_data <= s_data;
         end
      end
   end
   assign s_ready = r_ready;
   assign m_addr  = r_m_addr;
   assign m_data  = r_m_data;
   assign m_wr_en = r_m_wr_en;
   assign v_addr  = r_v_addr;
   assign v_data  = r_v_data;
   assign v_wr_en = r_v_wr_en;
   assign start   = r_state == START;
endmodule

// File: tb/tb_mvm_input_loader.sv
// tb_mvm_input_loader: directed checks of load sequencing, reuse, stalls, reset and start timing
module tb_mvm_input_loader;
   logic clk = 1'b0, reset = 1'b1;
   logic [15:0] s_data = '0;
   logic s_valid = 1'b0, s_new_matrix = 1'b0, compute_done = 1'b0;
   logic s_ready, m_wr_en, v_wr_en, start;
   logic [5:0] m_addr;
   logic [2:0] v_addr;
   logic [15:0] m_data, v_data;
   int total = 0, bad = 0;
   int cyc = 0, hs_cyc = 0, nstart = 0, start_cyc = 0, both = 0;
   int ma[$], md[$], va[$], vd[$], wc[$];

   mvm_input_loader dut (
      .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .s_new_matrix(s_new_matrix), .m_addr(m_addr), .m_data(m_data), .m_wr_en(m_wr_en),
      .v_addr(v_addr), .v_data(v_data), .v_wr_en(v_wr_en), .start(start),
      .compute_done(compute_done));

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc++;
      #1;
      if (m_wr_en) begin
         ma.push_back(int'(m_addr));
         md.push_back(int'(m_data));
         wc.push_back(cyc);
      end
      if (v_wr_en) begin
         va.push_back(int'(v_addr));
         vd.push_back(int'(v_data));
         wc.push_back(cyc);
      end
      if (m_wr_en && v_wr_en) both++;
      if (start) begin
         nstart++;
         start_cyc = cyc;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic clr_q();
      ma.delete(); md.delete(); va.delete(); vd.delete(); wc.delete();
   endtask

   task automatic send(input int d, input logic nm, input int gap);
      int n = 0;
      s_valid = 1'b0;
      repeat (gap) @(negedge clk);
      s_valid = 1'b1;
      s_data = 16'(d);
      s_new_matrix = nm;
      while (!s_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!s_ready) begin
         chk("ready_timeout", 0, 1);
         s_valid = 1'b0;
         return;
      end
      @(negedge clk);
      hs_cyc = cyc;
      s_valid = 1'b0;
   endtask

   task automatic load(input int n, input int base, input logic nm, input logic gaps);
      for (int i = 0; i < n; i++) send(base + i, nm, gaps ? int'($urandom_range(0, 2)) : 0);
   endtask

   task automatic chk_m(input int n, input int base);
      chk("m_count", ma.size(), n);
      for (int i = 0; i < ma.size() && i < n; i++) begin
         chk("m_addr", ma[i], i);
         chk("m_data", md[i], base + i);
      end
   endtask

   task automatic chk_v(input int n, input int base);
      chk("v_count", va.size(), n);
      for (int i = 0; i < va.size() && i < n; i++) begin
         chk("v_addr", va[i], i);
         chk("v_data", vd[i], base + i);
      end
   endtask

   task automatic wait_start();
      int ns0, n;
      ns0 = nstart;
      n = 0;
      while (nstart == ns0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("start_seen", nstart != ns0, 1);
      chk("start_lat", start_cyc - hs_cyc, 2);
      repeat (3) @(negedge clk);
      chk("start_once", nstart - ns0, 1);
   endtask

   task automatic done();
      chk("busy_ready", s_ready, 0);
      compute_done = 1'b1;
      @(negedge clk);
      compute_done = 1'b0;
      chk("idle_ready", s_ready, 1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      s_valid = 1'b0;
      @(negedge clk);
      chk("rst_ctl", {s_ready, m_wr_en, v_wr_en, start}, 0);
      chk("rst_addr", {m_addr, v_addr}, 0);
      chk("rst_data", {m_data, v_data}, 0);
      reset = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", s_ready, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      do_reset();
      clr_q();
      load(72, 1, 1'b1, 1'b0);
      chk_m(64, 1);
      chk_v(8, 65);
      chk("wr_count", wc.size(), 72);
      if (wc.size() == 72) chk("wr_span", wc[71] - wc[0], 71);
      wait_start();
      done();

      clr_q();
      load(8, 100, 1'b0, 1'b0);
      chk_m(0, 0);
      chk_v(8, 100);
      wait_start();
      done();

      do_reset();
      clr_q();
      load(8, 200, 1'b0, 1'b0);
      chk("forced_m", ma.size(), 8);
      chk("forced_nov", va.size(), 0);
      load(64, 208, 1'b0, 1'b0);
      chk_m(64, 200);
      chk_v(8, 264);
      wait_start();
      done();

      clr_q();
      load(72, 1, 1'b1, 1'b1);
      chk_m(64, 1);
      chk_v(8, 65);
      wait_start();
      done();

      do_reset();
      load(30, 1, 1'b1, 1'b0);
      do_reset();
      clr_q();
      load(72, 1, 1'b1, 1'b0);
      chk_m(64, 1);
      chk_v(8, 65);

      s_valid = 1'b1;
      s_data = 16'd555;
      s_new_matrix = 1'b0;
      compute_done = 1'b1;
      @(negedge clk);
      compute_done = 1'b0;
      chk("drain_ready", s_ready, 0);
      wait_start();
      chk("hold_v_count", va.size(), 8);
      done();
      @(negedge clk);
      s_valid = 1'b0;
      chk("reuse_v_count", va.size(), 9);
      if (va.size() == 9) begin
         chk("reuse_v_addr", va[8], 0);
         chk("reuse_v_data", vd[8], 555);
      end
      chk("reuse_m_count", ma.size(), 64);
      chk("both_we", both, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
